// File: rtl/bullet_ctrl.sv
// Bullet pool controller: allocates slots on fire, advances live bullets upward once per
// frame (one slot per cycle), and retires them on leaving the screen top or on a hit.
module bullet_ctrl #(
    parameter int unsigned N     = 4,
    parameter int unsigned SPEED = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              frame_tick,
    input  logic              fire,
    input  logic [10:0]       fire_x,
    input  logic [9:0]        fire_y,
    input  logic              hit,
    input  logic [2:0]        hit_idx,
    output logic [N-1:0]      valid,
    output logic [11*N-1:0]   pos_x,
    output logic [10*N-1:0]   pos_y,
    output logic              busy,
    output logic              full,
    output logic              fire_ack,
    output logic              fire_drop,
    output logic [3:0]        count
);

    localparam int unsigned IdxW = (N > 1) ? $clog2(N) : 1;
    typedef logic [IdxW-1:0] idx_t;
    localparam idx_t       LastIdx = idx_t'(N - 1);
    localparam logic [2:0] HitMask = 3'((1 << IdxW) - 1);
    localparam logic [9:0] SpeedY  = 10'(SPEED);

    typedef enum logic [0:0] {StIdle, StUpdate} state_e;

    state_e      state_q, state_d;
    idx_t        idx_q, idx_d;
    logic [N-1:0] valid_q, valid_d;
    logic [10:0] px_q [N];
    logic [10:0] px_d [N];
    logic [9:0]  py_q [N];
    logic [9:0]  py_d [N];
    logic [10:0] buf_x_q, buf_x_d;
    logic [9:0]  buf_y_q, buf_y_d;
    logic        fire_pend_q, fire_pend_d;
    logic        tick_pend_q, tick_pend_d;
    logic        ack_q, ack_d;
    logic        drop_q, drop_d;

    idx_t        free_slot;
    logic [2:0]  hit_sel;
    logic        hit_ok;
    idx_t        hit_slot;
    logic        alloc_en;

    // Lowest-index free slot; only meaningful when not full.
    always_comb begin
        free_slot = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (!valid_q[i]) free_slot = idx_t'(i);
        end
    end

    always_comb begin
        count = '0;
        for (int i = 0; i < N; i++) begin
            count = count + {3'd0, valid_q[i]};
        end
    end

    assign full     = &valid_q;
    assign hit_sel  = hit_idx & HitMask;
    assign hit_ok   = hit && ({29'd0, hit_sel} < N);
    assign hit_slot = hit_sel[IdxW-1:0];

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        valid_d     = valid_q;
        px_d        = px_q;
        py_d        = py_q;
        buf_x_d     = buf_x_q;
        buf_y_d     = buf_y_q;
        fire_pend_d = fire_pend_q;
        tick_pend_d = tick_pend_q;
        ack_d       = 1'b0;
        drop_d      = 1'b0;
        alloc_en    = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (fire_pend_q) begin
                    fire_pend_d = 1'b0;
                    if (!full) begin
                        alloc_en           = 1'b1;
                        valid_d[free_slot] = 1'b1;
                        px_d[free_slot]    = buf_x_q;
                        py_d[free_slot]    = buf_y_q;
                        ack_d              = 1'b1;
                    end else begin
                        drop_d = 1'b1;
                    end
                end else if (tick_pend_q) begin
                    state_d     = StUpdate;
                    idx_d       = '0;
                    tick_pend_d = 1'b0;
                end
            end
            StUpdate: begin
                // A hit on the slot being processed suppresses the move; the clear below wins.
                if (valid_q[idx_q] && !(hit_ok && hit_slot == idx_q)) begin
                    if (py_q[idx_q] <= SpeedY) begin
                        valid_d[idx_q] = 1'b0;
                    end else begin
                        py_d[idx_q] = py_q[idx_q] - SpeedY;
                    end
                end
                if (idx_q == LastIdx) begin
                    state_d = StIdle;
                    idx_d   = '0;
                end else begin
                    idx_d = idx_q + idx_t'(1);
                end
            end
            default: state_d = StIdle;
        endcase

        if (frame_tick) tick_pend_d = 1'b1;

        // One-deep buffer: a request arriving while one is held is discarded.
        if (fire) begin
            if (fire_pend_q) begin
                drop_d = 1'b1;
            end else begin
                fire_pend_d = 1'b1;
                buf_x_d     = fire_x;
                buf_y_d     = fire_y;
            end
        end

        if (hit_ok && !(alloc_en && hit_slot == free_slot)) begin
            valid_d[hit_slot] = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            idx_q       <= '0;
            valid_q     <= '0;
            buf_x_q     <= '0;
            buf_y_q     <= '0;
            fire_pend_q <= 1'b0;
            tick_pend_q <= 1'b0;
            ack_q       <= 1'b0;
            drop_q      <= 1'b0;
            for (int i = 0; i < N; i++) begin
                px_q[i] <= '0;
                py_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            valid_q     <= valid_d;
            buf_x_q     <= buf_x_d;
            buf_y_q     <= buf_y_d;
            fire_pend_q <= fire_pend_d;
            tick_pend_q <= tick_pend_d;
            ack_q       <= ack_d;
            drop_q      <= drop_d;
            for (int i = 0; i < N; i++) begin
                px_q[i] <= px_d[i];
                py_q[i] <= py_d[i];
            end
        end
    end

    for (genvar g = 0; g < N; g++) begin : g_out
        assign pos_x[11*g +: 11] = px_q[g];
        assign pos_y[10*g +: 10] = py_q[g];
    end

    assign valid     = valid_q;
    assign busy      = (state_q == StUpdate);
    assign fire_ack  = ack_q;
    assign fire_drop = drop_q;

endmodule

// File: tb/tb_bullet_ctrl.sv
// Bench for bullet_ctrl: directed opening, randomized traffic, and a reset in mid-pass,
// all compared each cycle against a slot-list reference model.
module tb_bullet_ctrl;

    localparam int N     = 4;
    localparam int SPEED = 4;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            frame_tick = 1'b0;
    logic            fire = 1'b0;
    logic [10:0]     fire_x = '0;
    logic [9:0]      fire_y = '0;
    logic            hit = 1'b0;
    logic [2:0]      hit_idx = '0;
    logic [N-1:0]    valid;
    logic [11*N-1:0] pos_x;
    logic [10*N-1:0] pos_y;
    logic            busy, full, fire_ack, fire_drop;
    logic [3:0]      count;

    bullet_ctrl #(.N(N), .SPEED(SPEED)) dut (
        .clk        (clk),
        .rst        (rst),
        .frame_tick (frame_tick),
        .fire       (fire),
        .fire_x     (fire_x),
        .fire_y     (fire_y),
        .hit        (hit),
        .hit_idx    (hit_idx),
        .valid      (valid),
        .pos_x      (pos_x),
        .pos_y      (pos_y),
        .busy       (busy),
        .full       (full),
        .fire_ack   (fire_ack),
        .fire_drop  (fire_drop),
        .count      (count)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: list of slots, a held request, a held tick, and the slot the
    // current pass will visit next (-1 when no pass is running).
    bit m_valid [N];
    int m_x [N];
    int m_y [N];
    bit m_fpend, m_tpend;
    int m_bx, m_by;
    int m_pass;
    bit m_ack, m_drop;

    task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_valid[i] = 0;
            m_x[i] = 0;
            m_y[i] = 0;
        end
        m_fpend = 0; m_tpend = 0; m_bx = 0; m_by = 0;
        m_pass = -1; m_ack = 0; m_drop = 0;
    endtask

    task automatic model_step(bit f, int fx, int fy, bit t, bit h, int hi);
        int alloc = -1;
        bit old_fpend = m_fpend;
        int hs = hi % N;
        int s;
        m_ack = 0;
        m_drop = 0;
        if (m_pass < 0) begin
            if (m_fpend) begin
                m_fpend = 0;
                for (int i = 0; i < N; i++) if (!m_valid[i] && alloc < 0) alloc = i;
                if (alloc >= 0) begin
                    m_valid[alloc] = 1;
                    m_x[alloc] = m_bx;
                    m_y[alloc] = m_by;
                    m_ack = 1;
                end else begin
                    m_drop = 1;
                end
            end else if (m_tpend) begin
                m_tpend = 0;
                m_pass = 0;
            end
        end else begin
            s = m_pass;
            if (m_valid[s] && !(h && hs == s)) begin
                if (m_y[s] <= SPEED) m_valid[s] = 0;
                else m_y[s] = m_y[s] - SPEED;
            end
            m_pass = (s == N - 1) ? -1 : s + 1;
        end
        if (t) m_tpend = 1;
        if (f) begin
            if (old_fpend) m_drop = 1;
            else begin
                m_fpend = 1;
                m_bx = fx;
                m_by = fy;
            end
        end
        if (h && hs != alloc) m_valid[hs] = 0;
    endtask

    task automatic compare();
        logic [N-1:0]    ev;
        logic [11*N-1:0] ex;
        logic [10*N-1:0] ey;
        int c = 0;
        for (int i = 0; i < N; i++) begin
            ev[i] = m_valid[i];
            ex[11*i +: 11] = 11'(m_x[i]);
            ey[10*i +: 10] = 10'(m_y[i]);
            c += int'(m_valid[i]);
        end
        check("valid", 64'(valid), 64'(ev));
        check("pos_x", 64'(pos_x), 64'(ex));
        check("pos_y", 64'(pos_y), 64'(ey));
        check("busy", 64'(busy), 64'(m_pass >= 0));
        check("full", 64'(full), 64'(c == N));
        check("count", 64'(count), 64'(c));
        check("fire_ack", 64'(fire_ack), 64'(m_ack));
        check("fire_drop", 64'(fire_drop), 64'(m_drop));
    endtask

    task automatic cycle(bit f, int fx, int fy, bit t, bit h, int hi);
        @(negedge clk);
        fire = f; fire_x = 11'(fx); fire_y = 10'(fy);
        frame_tick = t; hit = h; hit_idx = 3'(hi);
        @(posedge clk);
        model_step(f, fx, fy, t, h, hi);
        #1;
        compare();
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        int guard;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        compare();
        @(negedge clk);
        rst = 1'b0;

        // Fire, move, retire.
        cycle(1, 100, 10, 0, 0, 0);
        idle(2);
        for (int k = 0; k < 3; k++) begin
            cycle(0, 0, 0, 1, 0, 0);
            idle(6);
        end

        // Fill the pool, overflow, free a slot by hit, refill it.
        for (int k = 0; k < 5; k++) begin
            cycle(1, 200 + k, 500, 0, 0, 0);
            idle(2);
        end
        cycle(0, 0, 0, 0, 1, 2);
        cycle(1, 333, 444, 0, 0, 0);
        idle(2);

        // Fire and tick together, then a second fire inside the pass.
        cycle(0, 0, 0, 0, 1, 1);
        cycle(1, 50, 300, 1, 0, 0);
        cycle(0, 0, 0, 0, 0, 0);
        cycle(1, 60, 700, 0, 0, 0);
        cycle(1, 70, 800, 0, 1, 0);
        idle(8);

        // Randomized traffic.
        for (int k = 0; k < 3000; k++) begin
            cycle(($urandom_range(3) == 0),
                  $urandom_range(2047),
                  ($urandom_range(3) == 0) ? $urandom_range(1023) : $urandom_range(40),
                  ($urandom_range(11) == 0),
                  ($urandom_range(9) == 0),
                  $urandom_range(7));
        end

        // Reset in the middle of a pass.
        cycle(1, 10, 900, 0, 0, 0);
        idle(2);
        cycle(0, 0, 0, 1, 0, 0);
        guard = 0;
        while (m_pass != 2 && guard < 40) begin
            cycle(0, 0, 0, 0, 0, 0);
            guard++;
        end
        check("reach_pass_idx2", 64'(busy && guard < 40), 64'(1));
        #1 rst = 1'b1;
        #1;
        check("rst_valid", 64'(valid), 64'(0));
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_pos_y", 64'(pos_y), 64'(0));
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        idle(6);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
